udp_payload_buffer: RTL and testbench
=====================================

// Module: udp_payload_buffer
// PURPOSE
//  Byte-stream FIFO upstream of the GMII UDP transmitter; replaces its fixed test payload with user data.
//  Accepts bytes on a valid/ready input and buffers them in a circular RAM.
//  Advertises when one full payload of DATA_SIZE bytes is stored.
//  Replays that payload one byte per rd_en, for the transmitter's SEND_DATA phase.
// PARAMETERS
//  DATA_SIZE   1472   payload bytes per UDP packet (32..1500)
//  DEPTH       4096   buffer bytes; power of two, >= 2*DATA_SIZE
//  ADDR_W      $clog2(DEPTH)   pointer width (derived, not overridden)
// PORTS
//  sys_clk     in   1   single clock (same as GMII_GTXCLK)
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   write byte strobe
//  in_data     in   8   write byte
//  in_ready    out  1   buffer can accept in_data this cycle
//  pkt_avail   out  1   >= DATA_SIZE bytes stored and reader idle
//  rd_start    in   1   one-cycle pulse: claim one packet
//  rd_en       in   1   pop one byte of the claimed packet
//  rd_data     out  8   popped byte, valid cycle after rd_en
//  rd_valid    out  1   rd_data qualifier
//  rd_last     out  1   with rd_valid: final (DATA_SIZE-th) byte
//  pkt_csum    out  16  raw one's-complement payload sum (UDP_CSUM_EN only, else 16'h0000)
// BEHAVIOUR
//  Reset: wr_ptr=rd_ptr=0, count=0, state IDLE; in_ready=0 during reset then 1;
//   pkt_avail=0, rd_data=0, rd_valid=0, rd_last=0, pkt_csum=0.
//  Write: in_valid&in_ready writes RAM[wr_ptr], wr_ptr++ (wraps mod DEPTH), count++.
//   in_ready = (count != DEPTH) (registered/derived from count, no combinational path from in_valid).
//   in_valid while !in_ready: byte dropped, no state change.
//  Read FSM: IDLE -> (rd_start & count>=DATA_SIZE) -> READ; byte_cnt=0.
//   rd_start in READ or with count<DATA_SIZE: ignored.
//   READ: rd_en pops RAM[rd_ptr], rd_ptr++, count--, byte_cnt++.
//   Read latency is 1: rd_data/rd_valid are registered the cycle after rd_en.
//   byte_cnt==DATA_SIZE-1 with rd_en: rd_last=1 on that data cycle, FSM -> IDLE.
//   rd_en in IDLE: ignored, rd_valid=0. rd_en gaps allowed; rd_valid follows rd_en.
//  Simultaneous write and pop: count unchanged; both pointers advance.
//  Full and pop in same cycle: the write is refused, because in_ready already reflected full.
//  pkt_avail = (state==IDLE) & (count>=DATA_SIZE), registered; drops the cycle after rd_start.
//  count is ADDR_W+1 bits. Reset mid-packet discards all content; no partial resume.
// CONFIGURATION
//  UDP_CSUM_EN defined:
//   - Write side keeps a 17-bit end-around-carry adder.
//   - Even payload offsets form the high byte, odd offsets the low byte; an odd trailing byte is padded with 8'h00.
//   - Every DATA_SIZE written bytes, the folded 16-bit sum is pushed into a 4-entry csum FIFO and the accumulator is cleared.
//   - pkt_csum shows the FIFO head, stable from pkt_avail until the popping rd_last.
//   - pkt_avail additionally requires the csum FIFO to be non-empty.
//   - The value is not inverted: the consumer adds the pseudo-header, then inverts.
//  UDP_CSUM_EN undefined: no adder or FIFO; pkt_csum tied 16'h0000 (UDP "no checksum").
// STRUCTURE
//  gmii_pkg: rd_state_t enum {RD_IDLE, RD_READ}, default DATA_SIZE constant, CSUM_FIFO_DEPTH=4.
//  Sub-module udp_buf_ram: simple dual-port RAM, DEPTH x 8, sync write, 1-cycle registered read.
//  All remaining logic (pointers, count, FSM, checksum) lives in udp_payload_buffer.
// TESTING
//  1. Reset release, no input -> in_ready=1, pkt_avail=0; rd_start+rd_en x10 -> rd_valid never 1.
//  2. DATA_SIZE=32: write bytes 0..31, rd_start, rd_en x32 -> rd_data 0..31, rd_last on 31, pkt_avail=0.
//  3. DEPTH=64, DATA_SIZE=32, write 64 bytes then 1 more -> in_ready=0 after 64th, 65th dropped;
//     read 32 -> in_ready=1, count=32.
//  4. Concurrent stream in and pop, pointers crossing DEPTH-1 -> bytes in order, no loss.
//  5. rd_en toggling 1/0 mid-packet, rd_start repeated in READ -> ignored; 32 bytes in order.
//  6. UDP_CSUM_EN, payload 32 x 8'hFF -> pkt_csum=16'hFFFF;
//     payload 01,02 repeated -> pkt_csum=16'h1020.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared types and constants for the UDP payload buffer that feeds the GMII UDP transmitter.
package gmii_pkg;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_t;

   localparam int DEFAULT_DATA_SIZE = 1472;
   localparam int CSUM_FIFO_DEPTH   = 4;
   localparam int CSUM_PTR_W        = $clog2(CSUM_FIFO_DEPTH);

endpackage

// File: rtl/udp_buf_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read with a one-cycle latency.
module udp_buf_ram #(
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the output register is reset so rd_data reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 8'h00;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/udp_payload_buffer.sv
// Circular byte FIFO that stores user payload and replays one DATA_SIZE packet per claim.
// Optional feature macro: UDP_CSUM_EN (per-packet one's-complement payload sum in pkt_csum).
module udp_payload_buffer
   import gmii_pkg::*;
#(
   parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
   parameter int DEPTH     = 4096
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        pkt_avail,
   input  logic        rd_start,
   input  logic        rd_en,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        rd_last,
   output logic [15:0] pkt_csum
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BC_W   = $clog2(DATA_SIZE);
   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_PKT  = (ADDR_W+1)'(DATA_SIZE);
   localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_SIZE - 1);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   rd_state_t         state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              pkt_avail_q, pkt_avail_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;

   logic              wr_fire;
   logic              pop;
   logic              last_pop;
   logic              csum_ok;
   logic              csum_ok_d;
   logic              csum_block_d;

   udp_buf_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .we    (wr_fire),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .re    (pop),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   always_comb begin
      wr_fire     = in_valid & in_ready_q;
      pop         = rd_en & (state_q == RD_READ);
      last_pop    = pop & (byte_cnt_q == BC_LAST);

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      rd_valid_d  = pop;
      rd_last_d   = last_pop;

      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({wr_fire, pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         RD_IDLE: begin
            if (rd_start && (count_q >= CNT_PKT) && csum_ok) begin
               state_d    = RD_READ;
               byte_cnt_d = '0;
            end
         end
         RD_READ: begin
            if (pop) begin
               byte_cnt_d = byte_cnt_q + BC_W'(1);
               if (last_pop) begin
                  state_d = RD_IDLE;
               end
            end
         end
         default: state_d = RD_IDLE;
      endcase

      // Both flags look at next-cycle occupancy so they stay purely registered outputs.
      in_ready_d  = (count_d != CNT_FULL) && !csum_block_d;
      pkt_avail_d = (state_d == RD_IDLE) && (count_d >= CNT_PKT) && csum_ok_d;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= RD_IDLE;
         byte_cnt_q  <= '0;
         in_ready_q  <= 1'b0;
         pkt_avail_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         in_ready_q  <= in_ready_d;
         pkt_avail_q <= pkt_avail_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign pkt_avail = pkt_avail_q;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;

`ifdef UDP_CSUM_EN
   logic [BC_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic [7:0]            hi_q, hi_d;
   logic [15:0]           acc_q, acc_d;
   logic [15:0]           fifo_q [CSUM_FIFO_DEPTH];
   logic [15:0]           fifo_d [CSUM_FIFO_DEPTH];
   logic [CSUM_PTR_W-1:0] fwp_q, fwp_d;
   logic [CSUM_PTR_W-1:0] frp_q, frp_d;
   logic [CSUM_PTR_W:0]   fcnt_q, fcnt_d;
   logic [15:0]           word;
   logic [16:0]           add17;
   logic [15:0]           sum16;
   logic                  pkt_end;
   logic                  push;
   logic                  csum_pop;

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      hi_d     = hi_q;
      acc_d    = acc_q;
      fifo_d   = fifo_q;
      fwp_d    = fwp_q;
      frp_d    = frp_q;
      word     = 16'h0000;
      pkt_end  = wr_cnt_q == BC_LAST;
      push     = 1'b0;
      csum_pop = last_pop && (fcnt_q != '0);

      // Even offsets are the high byte; a trailing even-offset byte is padded with zero.
      if (!wr_cnt_q[0]) begin
         word = pkt_end ? {in_data, 8'h00} : 16'h0000;
      end else begin
         word = {hi_q, in_data};
      end
      add17 = {1'b0, acc_q} + {1'b0, word};
      sum16 = add17[15:0] + {15'b0, add17[16]};

      if (wr_fire) begin
         if (!wr_cnt_q[0]) begin
            hi_d = in_data;
         end
         acc_d = sum16;
         if (pkt_end) begin
            push           = 1'b1;
            fifo_d[fwp_q]  = sum16;
            fwp_d          = fwp_q + CSUM_PTR_W'(1);
            acc_d          = 16'h0000;
            wr_cnt_d       = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + BC_W'(1);
         end
      end

      if (csum_pop) begin
         frp_d = frp_q + CSUM_PTR_W'(1);
      end
      case ({push, csum_pop})
         2'b10:   fcnt_d = fcnt_q + (CSUM_PTR_W+1)'(1);
         2'b01:   fcnt_d = fcnt_q - (CSUM_PTR_W+1)'(1);
         default: fcnt_d = fcnt_q;
      endcase

      // Refuse only the byte that would complete a packet while the sum FIFO is full.
      csum_ok_d    = fcnt_d != '0;
      csum_block_d = (fcnt_d == (CSUM_PTR_W+1)'(CSUM_FIFO_DEPTH)) && (wr_cnt_d == BC_LAST);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q <= '0;
         hi_q     <= 8'h00;
         acc_q    <= 16'h0000;
         fwp_q    <= '0;
         frp_q    <= '0;
         fcnt_q   <= '0;
         for (int i = 0; i < CSUM_FIFO_DEPTH; i++) begin
            fifo_q[i] <= 16'h0000;
         end
      end else begin
         wr_cnt_q <= wr_cnt_d;
         hi_q     <= hi_d;
         acc_q    <= acc_d;
         fwp_q    <= fwp_d;
         frp_q    <= frp_d;
         fcnt_q   <= fcnt_d;
         fifo_q   <= fifo_d;
      end
   end

   assign csum_ok  = fcnt_q != '0;
   assign pkt_csum = csum_ok ? fifo_q[frp_q] : 16'h0000;
`else
   assign csum_ok      = 1'b1;
   assign csum_ok_d    = 1'b1;
   assign csum_block_d = 1'b0;
   assign pkt_csum     = 16'h0000;
`endif

endmodule

// File: tb/tb_udp_payload_buffer.sv
// Directed bench for udp_payload_buffer with DATA_SIZE=32, DEPTH=64.
module tb_udp_payload_buffer;

`ifdef UDP_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        pkt_avail;
   logic        rd_start;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic [15:0] pkt_csum;

   int n_tests = 0;
   int n_fail  = 0;

   udp_payload_buffer #(
      .DATA_SIZE (32),
      .DEPTH     (64)
   ) dut (
      .sys_clk   (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .pkt_avail (pkt_avail),
      .rd_start  (rd_start),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .pkt_csum  (pkt_csum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] cs(input logic [15:0] v);
      return CSUM_ON ? v : 16'h0000;
   endfunction

   function automatic logic [7:0] pat(input int k);
      return 8'((k * 7 + 3) & 8'hFF);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic claim();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] e, input logic l);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, "_valid"}, rd_valid, 1);
      chk({tag, "_data"}, rd_data, e);
      chk({tag, "_last"}, rd_last, l);
   endtask

   initial begin
      int j;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      rd_start = 1'b0;
      rd_en    = 1'b0;
      #23;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_pkt_avail", pkt_avail, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_last", rd_last, 0);
      chk("rst_pkt_csum", pkt_csum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t1_in_ready", in_ready, 1);
      chk("t1_pkt_avail", pkt_avail, 0);

      // Test 1: claim and pop on an empty buffer
      rd_start = 1'b1;
      rd_en    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t1_rd_valid", rd_valid, 0);
      end
      rd_start = 1'b0;
      rd_en    = 1'b0;
      chk("t1_pkt_avail_end", pkt_avail, 0);

      // Test 2: one packet 0..31
      for (int i = 0; i < 32; i++) wr(8'(i));
      chk("t2_pkt_avail", pkt_avail, 1);
      chk("t2_csum", pkt_csum, cs(16'hF100));
      claim();
      chk("t2_avail_drop", pkt_avail, 0);
      chk("t2_csum_hold", pkt_csum, cs(16'hF100));
      for (int i = 0; i < 32; i++) pop_chk("t2", 8'(i), i == 31);
      tick();
      chk("t2_valid_end", rd_valid, 0);
      chk("t2_avail_end", pkt_avail, 0);
      chk("t2_csum_end", pkt_csum, 0);

      // Test 3: fill to DEPTH, overflow byte dropped
      for (int i = 0; i < 64; i++) wr(8'(100 + i));
      chk("t3_full_ready", in_ready, 0);
      wr(8'hEE);
      chk("t3_count_full", dut.count_q, 64);
      chk("t3_still_full", in_ready, 0);
      claim();
      for (int i = 0; i < 32; i++) pop_chk("t3a", 8'(100 + i), i == 31);
      chk("t3_ready_back", in_ready, 1);
      chk("t3_count_half", dut.count_q, 32);
      chk("t3_avail_half", pkt_avail, 1);
      claim();
      for (int i = 0; i < 32; i++) pop_chk("t3b", 8'(132 + i), i == 31);
      chk("t3_count_empty", dut.count_q, 0);

      // Test 4: concurrent write and pop, pointers wrapping
      for (int i = 0; i < 32; i++) wr(pat(i));
      claim();
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_data  = pat(32 + i);
         rd_en    = 1'b1;
         tick();
         in_valid = 1'b0;
         rd_en    = 1'b0;
         chk("t4_valid", rd_valid, 1);
         chk("t4_data", rd_data, pat(i));
         chk("t4_last", rd_last, i == 31);
      end
      chk("t4_count", dut.count_q, 32);
      chk("t4_avail", pkt_avail, 1);
      claim();
      for (int i = 0; i < 32; i++) pop_chk("t4b", pat(32 + i), i == 31);
      chk("t4_count_end", dut.count_q, 0);

      // Test 5: gapped rd_en, rd_start repeated while reading
      for (int i = 0; i < 32; i++) wr(8'(8'hA0 + i));
      claim();
      j = 0;
      for (int c = 0; c < 64; c++) begin
         rd_en    = (c % 2) == 0;
         rd_start = (c == 10) || (c == 20);
         tick();
         rd_start = 1'b0;
         if ((c % 2) == 0) begin
            chk("t5_valid", rd_valid, 1);
            chk("t5_data", rd_data, 8'(8'hA0 + j));
            chk("t5_last", rd_last, j == 31);
            j++;
         end else begin
            chk("t5_gap", rd_valid, 0);
         end
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("t5_idle_pop", rd_valid, 0);
      chk("t5_count", dut.count_q, 0);
      chk("t5_avail", pkt_avail, 0);

      // Test 6: checksum patterns
      for (int i = 0; i < 32; i++) wr(8'hFF);
      chk("t6_avail_ff", pkt_avail, 1);
      chk("t6_csum_ff", pkt_csum, cs(16'hFFFF));
      claim();
      for (int i = 0; i < 32; i++) pop_chk("t6a", 8'hFF, i == 31);
      chk("t6_csum_clr", pkt_csum, 0);
      for (int i = 0; i < 16; i++) begin
         wr(8'h01);
         wr(8'h02);
      end
      chk("t6_csum_0102", pkt_csum, cs(16'h1020));
      claim();
      for (int i = 0; i < 32; i++) pop_chk("t6b", (i % 2 == 0) ? 8'h01 : 8'h02, i == 31);
      chk("t6_avail_end", pkt_avail, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
